fractal_pixel_scheduler: RTL and testbench

Head/tail controller for a closed ring of chained fractal kernel stages. Takes pixel coordinates from an input stream and injects them into free ring slots with z = 0. Watches every slot as it returns from the kernel chain: unfinished pixels are recirculated, and finished pixels are retired to a result stream as (iteration count, tag). It is the feeder for the kernel chain's inputs and the consumer of its outputs.

---
 rtl/fractal_pixel_scheduler.sv | 177 +++++++++++++++++
 tb/tb_fractal_pixel_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_pixel_scheduler.sv
// fractal_pixel_scheduler
// Head/tail controller for a closed ring of fractal kernel stages. New pixels
// go into free ring slots. Unfinished slots are recirculated. Finished slots
// are retired to a single-entry result register.
// Optional statistics counters are built when FRACTAL_SCHEDULER_STATS_EN is
// defined.
// The round trip is RING_LATENCY cycles including this block's output
// register, so the ring holds exactly RING_LATENCY slots.
module fractal_pixel_scheduler #(
   parameter int DATA_WIDTH   = 32,
   parameter int TAG_WIDTH    = 21,
   parameter int RING_LATENCY = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_cr,
   input  logic [DATA_WIDTH-1:0] s_ci,
   input  logic [TAG_WIDTH-1:0]  s_tag,
   input  logic [DATA_WIDTH-1:0] ring_zr_in,
   input  logic [DATA_WIDTH-1:0] ring_zi_in,
   input  logic [DATA_WIDTH-1:0] ring_cr_in,
   input  logic [DATA_WIDTH-1:0] ring_ci_in,
   input  logic [7:0]            ring_iter_in,
   input  logic                  ring_finished_in,
   output logic [DATA_WIDTH-1:0] ring_zr_out,
   output logic [DATA_WIDTH-1:0] ring_zi_out,
   output logic [DATA_WIDTH-1:0] ring_cr_out,
   output logic [DATA_WIDTH-1:0] ring_ci_out,
   output logic [7:0]            ring_iter_out,
   output logic                  ring_finished_out,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [7:0]            m_iter,
   output logic [TAG_WIDTH-1:0]  m_tag,
   output logic                  idle
`ifdef FRACTAL_SCHEDULER_STATS_EN
   ,
   output logic [31:0]           stat_accepted,
   output logic [31:0]           stat_retired,
   output logic [31:0]           stat_stalls
`endif
);

   localparam int CNT_W = $clog2(RING_LATENCY + 1);

   // Occupancy and tag travel beside the ring data. Stage 0 loads on the same
   // edge as ring_*_out, and the last stage lines up with ring_*_in.
   logic [RING_LATENCY-1:0] dl_occ;
   logic [TAG_WIDTH-1:0]    dl_tag [RING_LATENCY];
   logic                    tail_occ;
   logic [TAG_WIDTH-1:0]    tail_tag;

   logic                    res_free;
   logic                    recirc;
   logic                    retire;
   logic                    stall;
   logic                    accept;

   logic [DATA_WIDTH-1:0]   nxt_zr, nxt_zi, nxt_cr, nxt_ci;
   logic [7:0]              nxt_iter;
   logic                    nxt_fin;
   logic                    nxt_occ;
   logic [TAG_WIDTH-1:0]    nxt_tag;

   logic [CNT_W-1:0]        inflight_cnt;

   assign tail_occ = dl_occ[RING_LATENCY-1];
   assign tail_tag = dl_tag[RING_LATENCY-1];

   // A finished slot that cannot retire keeps circulating, so it still owns
   // its slot and blocks injection.
   assign res_free = !m_valid || m_ready;
   assign recirc   = tail_occ && (!ring_finished_in || !res_free);
   assign retire   = tail_occ && ring_finished_in && res_free;
   assign stall    = tail_occ && ring_finished_in && !res_free;
   assign s_ready  = !recirc;
   assign accept   = s_valid && s_ready;
   assign idle     = (inflight_cnt == '0) && !m_valid;

   // Select what goes into the head slot this cycle.
   always_comb begin
      nxt_zr   = '0;
      nxt_zi   = '0;
      nxt_cr   = '0;
      nxt_ci   = '0;
      nxt_iter = '0;
      nxt_fin  = 1'b0;
      nxt_occ  = 1'b0;
      nxt_tag  = '0;
      if (recirc) begin
         nxt_zr   = ring_zr_in;
         nxt_zi   = ring_zi_in;
         nxt_cr   = ring_cr_in;
         nxt_ci   = ring_ci_in;
         nxt_iter = ring_iter_in;
         nxt_fin  = ring_finished_in;
         nxt_occ  = 1'b1;
         nxt_tag  = tail_tag;
      end else if (accept) begin
         nxt_cr   = s_cr;
         nxt_ci   = s_ci;
         nxt_occ  = 1'b1;
         nxt_tag  = s_tag;
      end
   end

   // Ring head register and occupancy/tag delay line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ring_zr_out       <= '0;
         ring_zi_out       <= '0;
         ring_cr_out       <= '0;
         ring_ci_out       <= '0;
         ring_iter_out     <= '0;
         ring_finished_out <= 1'b0;
         dl_occ            <= '0;
         for (int i = 0; i < RING_LATENCY; i++) dl_tag[i] <= '0;
      end else begin
         ring_zr_out       <= nxt_zr;
         ring_zi_out       <= nxt_zi;
         ring_cr_out       <= nxt_cr;
         ring_ci_out       <= nxt_ci;
         ring_iter_out     <= nxt_iter;
         ring_finished_out <= nxt_fin;
         dl_occ            <= {dl_occ[RING_LATENCY-2:0], nxt_occ};
         dl_tag[0]         <= nxt_tag;
         for (int i = 1; i < RING_LATENCY; i++) dl_tag[i] <= dl_tag[i-1];
      end
   end

   // Result register holds its contents until the consumer takes them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_iter  <= '0;
         m_tag   <= '0;
      end else if (retire) begin
         m_valid <= 1'b1;
         m_iter  <= ring_iter_in;
         m_tag   <= tail_tag;
      end else if (m_valid && m_ready) begin
         m_valid <= 1'b0;
      end
   end

   // Count of occupied ring slots. A retire and an accept in the same cycle
   // cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_cnt <= '0;
      end else begin
         case ({accept, retire})
            2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
            2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
            default: inflight_cnt <= inflight_cnt;
         endcase
      end
   end

`ifdef FRACTAL_SCHEDULER_STATS_EN
   // Free-running wrap-around event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_accepted <= '0;
         stat_retired  <= '0;
         stat_stalls   <= '0;
      end else begin
         if (accept) stat_accepted <= stat_accepted + 32'd1;
         if (retire) stat_retired  <= stat_retired + 32'd1;
         if (stall)  stat_stalls   <= stat_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fractal_pixel_scheduler.sv
// Bench for fractal_pixel_scheduler with RING_LATENCY = 4.
// The kernel ring model adds three registers after the scheduler's output
// register. Unfinished slots get iter+1. A slot is marked finished when its
// new iter equals fin_at[ci[3:0]], where 0 means the slot never finishes.
module tb_fractal_pixel_scheduler;
   localparam int DW = 32;
   localparam int TW = 21;
   localparam int RL = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_cr = '0, s_ci = '0;
   logic [TW-1:0] s_tag = '0;
   logic [DW-1:0] ring_zr_in, ring_zi_in, ring_cr_in, ring_ci_in;
   logic [7:0]    ring_iter_in;
   logic          ring_finished_in;
   logic [DW-1:0] ring_zr_out, ring_zi_out, ring_cr_out, ring_ci_out;
   logic [7:0]    ring_iter_out;
   logic          ring_finished_out;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [7:0]    m_iter;
   logic [TW-1:0] m_tag;
   logic          idle;
`ifdef FRACTAL_SCHEDULER_STATS_EN
   logic [31:0]   stat_accepted, stat_retired, stat_stalls;
`endif

   int nvec = 0;
   int nmis = 0;

   fractal_pixel_scheduler #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .RING_LATENCY(RL)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_cr(s_cr), .s_ci(s_ci), .s_tag(s_tag),
      .ring_zr_in(ring_zr_in), .ring_zi_in(ring_zi_in), .ring_cr_in(ring_cr_in),
      .ring_ci_in(ring_ci_in), .ring_iter_in(ring_iter_in), .ring_finished_in(ring_finished_in),
      .ring_zr_out(ring_zr_out), .ring_zi_out(ring_zi_out), .ring_cr_out(ring_cr_out),
      .ring_ci_out(ring_ci_out), .ring_iter_out(ring_iter_out), .ring_finished_out(ring_finished_out),
      .m_valid(m_valid), .m_ready(m_ready), .m_iter(m_iter), .m_tag(m_tag), .idle(idle)
`ifdef FRACTAL_SCHEDULER_STATS_EN
      , .stat_accepted(stat_accepted), .stat_retired(stat_retired), .stat_stalls(stat_stalls)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural kernel ring.
   typedef struct packed {
      logic [DW-1:0] zr, zi, cr, ci;
      logic [7:0]    iter;
      logic          fin;
   } slot_t;

   logic [7:0] fin_at [16];
   slot_t      rm [RL-1];
   slot_t      cur_out;

   assign cur_out = {ring_zr_out, ring_zi_out, ring_cr_out, ring_ci_out, ring_iter_out, ring_finished_out};

   function automatic slot_t kern(input slot_t s);
      slot_t r;
      r = s;
      if (!s.fin) begin
         r.iter = s.iter + 8'd1;
         r.fin  = (fin_at[s.ci[3:0]] != 8'd0) && (r.iter == fin_at[s.ci[3:0]]);
      end
      return r;
   endfunction

   always @(posedge clk) begin
      rm[0] <= kern(cur_out);
      for (int i = 1; i < RL - 1; i++) rm[i] <= rm[i-1];
   end

   assign ring_zr_in       = rm[RL-2].zr;
   assign ring_zi_in       = rm[RL-2].zi;
   assign ring_cr_in       = rm[RL-2].cr;
   assign ring_ci_in       = rm[RL-2].ci;
   assign ring_iter_in     = rm[RL-2].iter;
   assign ring_finished_in = rm[RL-2].fin;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic inject(input logic [TW-1:0] tag, input logic [3:0] key, input logic [DW-1:0] cr);
      s_valid = 1'b1;
      s_tag   = tag;
      s_ci    = {28'd0, key};
      s_cr    = cr;
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   typedef struct {
      logic [TW-1:0] tag;
      logic [DW-1:0] cr;
      logic [3:0]    key;
      logic [7:0]    n;
   } vec_t;

   vec_t vt [4];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, acc, w, nh, seen;
      logic [TW-1:0] got_tag [2];
      logic [7:0]    got_iter [2];

      vt[0] = '{tag: 21'd5,       cr: 32'h0000_0000, key: 4'd1, n: 8'd3};
      vt[1] = '{tag: 21'h1F_FFFF, cr: 32'hF000_0001, key: 4'd2, n: 8'd1};
      vt[2] = '{tag: 21'd0,       cr: 32'h1000_0000, key: 4'd3, n: 8'd2};
      vt[3] = '{tag: 21'd12345,   cr: 32'hDEAD_BEEF, key: 4'd4, n: 8'd5};
      for (int i = 0; i < 16; i++) fin_at[i] = 8'd0;

      // Reset held for three cycles
      repeat (3) @(negedge clk);
      chk("rst ring_zr_out", ring_zr_out, 0);
      chk("rst ring_cr_out", ring_cr_out, 0);
      chk("rst ring_iter_out", ring_iter_out, 0);
      chk("rst ring_finished_out", ring_finished_out, 0);
      chk("rst m_valid", m_valid, 0);
      chk("rst m_iter", m_iter, 0);
      chk("rst m_tag", m_tag, 0);
      chk("rst idle", idle, 1);
      rst = 1'b0;
      @(negedge clk);
      chk("post-rst s_ready", s_ready, 1);

      // Table of single pixels, each alone in the ring
      for (int v = 0; v < 4; v++) begin
         fin_at[vt[v].key] = vt[v].n;
         chk("vec s_ready", s_ready, 1);
         inject(vt[v].tag, vt[v].key, vt[v].cr);
         chk("vec inject cr", ring_cr_out, vt[v].cr);
         chk("vec inject zr", ring_zr_out, 0);
         chk("vec inject iter", ring_iter_out, 0);
         lat = 1;
         while (!m_valid && lat < 200) begin
            @(negedge clk);
            lat++;
         end
         chk("vec latency", lat, vt[v].n * RL + 1);
         chk("vec m_iter", m_iter, vt[v].n);
         chk("vec m_tag", m_tag, vt[v].tag);
         @(negedge clk);
         chk("vec m_valid drop", m_valid, 0);
         chk("vec idle", idle, 1);
      end

      // Fill: a never-finishing stream occupies exactly RL slots
      acc = 0;
      s_valid = 1'b1;
      s_ci = 32'd6;
      for (int i = 0; i < 12; i++) begin
         s_tag = TW'(10 + acc);
         if (s_ready) acc++;
         @(negedge clk);
      end
      s_valid = 1'b0;
      chk("fill accepts", acc, RL);
      chk("fill s_ready", s_ready, 0);
      chk("fill idle", idle, 0);
      pulse_rst();
      chk("fill clear idle", idle, 1);

      // Backpressure: tags 1 and 2 finish on consecutive cycles
      m_ready = 1'b0;
      fin_at[9]  = 8'd1;
      fin_at[10] = 8'd1;
      s_valid = 1'b1; s_tag = 21'd1; s_ci = 32'd9; s_cr = 32'd0;
      @(negedge clk);
      s_tag = 21'd2; s_ci = 32'd10;
      @(negedge clk);
      s_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("bp m_valid", m_valid, 1);
      chk("bp m_tag first", m_tag, 1);
      @(negedge clk);
      chk("bp recirc finished", ring_finished_out, 1);
      chk("bp recirc iter", ring_iter_out, 1);
      repeat (6) @(negedge clk);
      chk("bp hold m_valid", m_valid, 1);
      chk("bp hold m_tag", m_tag, 1);
      chk("bp hold m_iter", m_iter, 1);
      m_ready = 1'b1;
      nh = 0;
      for (int i = 0; i < 20; i++) begin
         if (m_valid && nh < 2) begin
            got_tag[nh]  = m_tag;
            got_iter[nh] = m_iter;
            nh++;
         end
         @(negedge clk);
      end
      chk("bp handshakes", nh, 2);
      chk("bp order tag 1", got_tag[0], 1);
      chk("bp order tag 2", got_tag[1], 2);
      chk("bp tag 2 iter", got_iter[1], 1);
      chk("bp drained idle", idle, 1);
`ifdef FRACTAL_SCHEDULER_STATS_EN
      chk("stat_stalls nonzero", stat_stalls != 0, 1);
      chk("stat_retired nonzero", stat_retired != 0, 1);
      chk("stat accepted>=retired", stat_accepted >= stat_retired, 1);
`endif

      // Same-cycle retire of tag 7 and accept of tag 9 on a full ring
      fin_at[11] = 8'd2;
      fin_at[12] = 8'd0;
      inject(21'd7, 4'd11, 32'd0);
      inject(21'd40, 4'd6, 32'd0);
      inject(21'd41, 4'd6, 32'd0);
      inject(21'd42, 4'd6, 32'd0);
      s_valid = 1'b1; s_tag = 21'd9; s_ci = 32'd12; s_cr = 32'h1234_5678;
      w = 0;
      while (!s_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("same-cycle wait", w, 4);
      chk("same-cycle finished in", ring_finished_in, 1);
      chk("same-cycle count before", dut.inflight_cnt, 4);
      @(negedge clk);
      s_valid = 1'b0;
      chk("same-cycle m_valid", m_valid, 1);
      chk("same-cycle m_tag", m_tag, 7);
      chk("same-cycle m_iter", m_iter, 2);
      chk("same-cycle inject cr", ring_cr_out, 32'h1234_5678);
      chk("same-cycle inject iter", ring_iter_out, 0);
      chk("same-cycle inject fin", ring_finished_out, 0);
      chk("same-cycle count after", dut.inflight_cnt, 4);
      pulse_rst();

      // Mid-run reset with three pixels in flight
      fin_at[13] = 8'd2;
      inject(21'd50, 4'd13, 32'd0);
      inject(21'd51, 4'd13, 32'd0);
      inject(21'd52, 4'd13, 32'd0);
      @(negedge clk);
      pulse_rst();
      seen = 0;
      for (int i = 0; i < 3 * RL + 4; i++) begin
         if (m_valid) seen++;
         @(negedge clk);
      end
      chk("midrst no m_valid", seen, 0);
      chk("midrst idle", idle, 1);
      fin_at[14] = 8'd1;
      inject(21'd60, 4'd14, 32'd0);
      lat = 1;
      while (!m_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("midrst next latency", lat, RL + 1);
      chk("midrst next m_tag", m_tag, 60);
      chk("midrst next m_iter", m_iter, 1);
      @(negedge clk);
      chk("midrst final idle", idle, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
